// File: rtl/gray_pkg.sv
// Shared types and Gray/binary helpers for the Gray-sequence checker.
// Helpers work on 32-bit values; callers zero-extend narrower codes and truncate the result.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_ACQ   = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Zero upper bits leave the low WIDTH bits unaffected, so one body serves every WIDTH <= 32.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_checker_if.sv
// Signal bundle between the Gray counter environment and the sequence checker.
// No valid/ready handshake: every rising clk edge is one sample of gray_in and cen.
interface gray_seq_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             cen;
    logic [WIDTH-1:0] gray_in;
    logic             clr_err;
    logic [WIDTH-1:0] bin_out;
    logic             step_err;
    logic             wrap_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state;

    modport master (
        output cen, gray_in, clr_err,
        input  bin_out, step_err, wrap_pulse, err_cnt, state
    );

    modport slave (
        input  cen, gray_in, clr_err,
        output bin_out, step_err, wrap_pulse, err_cnt, state
    );
endinterface

// File: rtl/gray2bin_conv.sv
// Combinational WIDTH-bit Gray-to-binary converter: each binary bit is the XOR of
// the Gray bits at and above it.
module gray2bin_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_seq_checker.sv
// Checks a Gray counter's output stream against its enable: +1 step when cen was
// high on the previous edge, hold otherwise. Reports wraps, step errors and a sticky fault.
module gray_seq_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    gray_seq_checker_if.slave chk
);

    logic [WIDTH-1:0] g_q;
    logic             cen_q;
    logic [WIDTH-1:0] bin_in;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] exp_g;

    logic [WIDTH-1:0] bin_r;
    logic             step_r;
    logic             wrap_r;
    logic [ERR_W-1:0] cnt_r;
    state_t           state_q;

    state_t           state_d;
    logic             step_d;
    logic             wrap_d;
    logic [ERR_W-1:0] cnt_d;

    gray2bin_conv #(.WIDTH(WIDTH)) u_conv_in (
        .gray (chk.gray_in),
        .bin  (bin_in)
    );

    gray2bin_conv #(.WIDTH(WIDTH)) u_conv_q (
        .gray (g_q),
        .bin  (bin_q)
    );

    // The counter moves on the edge after it sees cen, so the previous cen selects step vs hold.
    assign bin_inc = bin_q + WIDTH'(1);
    assign exp_g   = cen_q ? WIDTH'(bin2gray(GRAY_MAX_W'(bin_inc))) : g_q;

    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_r;
        if (chk.clr_err) begin
            state_d = ST_ACQ;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACQ: state_d = ST_TRACK;
                ST_TRACK: begin
                    if (chk.gray_in == exp_g) begin
                        wrap_d = cen_q && (bin_q == '1);
                    end else begin
                        step_d  = 1'b1;
                        state_d = ST_FAULT;
                        if (cnt_r != '1) cnt_d = cnt_r + ERR_W'(1);
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_ACQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q     <= '0;
            cen_q   <= 1'b0;
            bin_r   <= '0;
            step_r  <= 1'b0;
            wrap_r  <= 1'b0;
            cnt_r   <= '0;
            state_q <= ST_ACQ;
        end else begin
            g_q     <= chk.gray_in;
            cen_q   <= chk.cen;
            bin_r   <= bin_in;
            step_r  <= step_d;
            wrap_r  <= wrap_d;
            cnt_r   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign chk.bin_out    = bin_r;
    assign chk.step_err   = step_r;
    assign chk.wrap_pulse = wrap_r;
    assign chk.err_cnt    = cnt_r;
    assign chk.state      = state_q;

endmodule
